// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the multicycle MIPS datapath: sequences register enables and mux selects.
// Optional MEM_WAIT_EN: FETCH/MEM_READ/MEM_WRITE stall until memReady.
module multicycle_ctrl_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctl_t;

    state_t     st;
    state_t     nxt;
    ctl_t       ctl;
    logic [5:0] op_q;
    logic       fetch_go;

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:     begin c.pcw = 1'b1; c.mrd = 1'b1; c.irw = 1'b1; c.srcb = 2'd1; end
            S_DECODE:    c.srcb = 2'd3;
            S_MEM_ADDR:  begin c.srca = 1'b1; c.srcb = 2'd2; end
            S_MEM_READ:  begin c.mrd = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:    begin c.rw = 1'b1; c.m2r = 1'b1; end
            S_MEM_WRITE: begin c.mwr = 1'b1; c.iord = 1'b1; end
            S_EXEC:      begin c.srca = 1'b1; c.aluop = 2'd2; end
            S_R_WB:      begin c.rw = 1'b1; c.rdst = 1'b1; end
            S_BRANCH:    begin c.srca = 1'b1; c.aluop = 2'd1; c.pcwc = 1'b1; c.pcsrc = 2'd1; end
            S_JUMP:      begin c.pcw = 1'b1; c.pcsrc = 2'd2; end
            S_ADDI_EXEC: begin c.srca = 1'b1; c.srcb = 2'd2; end
            S_ADDI_WB:   c.rw = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = S_FETCH;
        case (st)
`ifdef MEM_WAIT_EN
            S_FETCH:     nxt = memReady ? S_DECODE : S_FETCH;
            S_MEM_READ:  nxt = memReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: nxt = memReady ? S_FETCH  : S_MEM_WRITE;
`else
            S_FETCH:     nxt = S_DECODE;
            S_MEM_READ:  nxt = S_MEM_WB;
            S_MEM_WRITE: nxt = S_FETCH;
`endif
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    OP_ADDI:      nxt = S_ADDI_EXEC;
                    default:      nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (op_q == OP_LW)      nxt = S_MEM_READ;
                else if (op_q == OP_SW) nxt = S_MEM_WRITE;
                else                    nxt = S_FETCH;
            end
            S_EXEC:      nxt = S_R_WB;
            S_ADDI_EXEC: nxt = S_ADDI_WB;
            default:     nxt = S_FETCH;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with st.
    always_ff @(posedge CLK) begin
        if (RST) begin
            st   <= S_FETCH;
            ctl  <= decode(S_FETCH);
            op_q <= '0;
        end else begin
            st  <= nxt;
            ctl <= decode(nxt);
            if (st == S_DECODE) op_q <= opcode;
        end
    end

`ifdef MEM_WAIT_EN
    assign fetch_go = (st != S_FETCH) || memReady;
`else
    logic unused_memready;
    assign unused_memready = memReady;
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        illegalOp = 1'b0;
        if (st == S_DECODE) begin
            case (opcode)
                OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegalOp = 1'b0;
                default: illegalOp = 1'b1;
            endcase
        end
    end

    // PC/IR enables in FETCH are gated so the PC advances exactly once per fetch.
    assign PCWrite     = ctl.pcw & fetch_go;
    assign IRWrite     = ctl.irw & fetch_go;
    assign PCWriteCond = ctl.pcwc;
    assign IorD        = ctl.iord;
    assign MemRead     = ctl.mrd;
    assign MemWrite    = ctl.mwr;
    assign MemtoReg    = ctl.m2r;
    assign RegDst      = ctl.rdst;
    assign RegWrite    = ctl.rw;
    assign ALUSrcA     = ctl.srca;
    assign ALUSrcB     = ctl.srcb;
    assign ALUOp       = ctl.aluop;
    assign PCSource    = ctl.pcsrc;
    assign state       = st;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle expected state/controls queued by stimulus,
// popped and compared by a negedge monitor. Wait-state vectors apply when MEM_WAIT_EN is defined.
module tb_multicycle_ctrl_fsm;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] opcode = OP_LW;
    logic       memReady = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    multicycle_ctrl_fsm dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .memReady(memReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegalOp(illegalOp), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctl;
        int          id;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int step_id = 0;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegalOp}
    function automatic logic [16:0] ctl_exp(input logic [3:0] s, input logic [5:0] op, input logic mr);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rdst = 0, rw = 0, srca = 0, ill = 0;
        logic [1:0] srcb = 0, aluop = 0, pcsrc = 0;
        case (s)
            4'd0: begin
                pcw = 1; mrd = 1; irw = 1; srcb = 2'd1;
`ifdef MEM_WAIT_EN
                if (!mr) begin pcw = 0; irw = 0; end
`endif
            end
            4'd1: begin
                srcb = 2'd3;
                ill = !(op == OP_LW || op == OP_SW || op == OP_RTYPE ||
                        op == OP_BEQ || op == OP_J || op == OP_ADDI);
            end
            4'd2:  begin srca = 1; srcb = 2'd2; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin srca = 1; aluop = 2'd2; end
            4'd7:  begin rw = 1; rdst = 1; end
            4'd8:  begin srca = 1; aluop = 2'd1; pcwc = 1; pcsrc = 2'd1; end
            4'd9:  begin pcw = 1; pcsrc = 2'd2; end
            4'd10: begin srca = 1; srcb = 2'd2; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, ill};
    endfunction

    // Inputs set here are sampled at the next posedge; st is the state expected during this cycle.
    task automatic step(input logic rst, input logic [5:0] op, input logic mr, input logic [3:0] st);
        exp_t e;
        @(posedge CLK);
        #1;
        RST = rst;
        opcode = op;
        memReady = mr;
        e.st = st;
        e.ctl = ctl_exp(st, op, mr);
        e.id = step_id;
        step_id++;
        sb.push_back(e);
    endtask

    // seq holds states one nibble each, first state in the low nibble.
    task automatic run(input logic [5:0] op, input int n, input logic [31:0] seq, input logic mr);
        for (int i = 0; i < n; i++) step(1'b0, op, mr, seq[4*i +: 4]);
    endtask

    initial begin : monitor
        exp_t e;
        logic [16:0] act;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegalOp};
                total++;
                if (state !== e.st) begin
                    bad++;
                    $display("FAIL step%0d state: got %0d want %0d", e.id, state, e.st);
                end
                total++;
                if (act !== e.ctl) begin
                    bad++;
                    $display("FAIL step%0d controls: got %05h want %05h", e.id, act, e.ctl);
                end
                total++;
                if (MemRead && MemWrite) begin
                    bad++;
                    $display("FAIL step%0d mem_excl: got rd=%0b wr=%0b want not both", e.id, MemRead, MemWrite);
                end
            end
        end
    end

    initial begin : stimulus
        // reset held across two posedges, then LW
        step(1'b1, OP_LW, 1'b1, 4'd0);
        run(OP_LW,    5, 32'h43210, 1'b1);
        run(OP_SW,    4, 32'h5210,  1'b1);
        run(OP_RTYPE, 4, 32'h7610,  1'b1);
        run(OP_BEQ,   3, 32'h810,   1'b1);
        run(OP_J,     3, 32'h910,   1'b1);
        run(OP_ADDI,  4, 32'hBA10,  1'b1);
        run(6'b111111, 2, 32'h10,   1'b1);
        run(6'b000011, 2, 32'h10,   1'b1);
        // reset asserted during MEM_READ of an LW
        step(1'b0, OP_LW, 1'b1, 4'd0);
        step(1'b0, OP_LW, 1'b1, 4'd1);
        step(1'b0, OP_LW, 1'b1, 4'd2);
        step(1'b1, OP_LW, 1'b1, 4'd3);
        run(OP_RTYPE, 4, 32'h7610, 1'b1);
`ifdef MEM_WAIT_EN
        step(1'b0, OP_LW, 1'b0, 4'd0);
        step(1'b0, OP_LW, 1'b0, 4'd0);
        step(1'b0, OP_LW, 1'b0, 4'd0);
        step(1'b0, OP_LW, 1'b1, 4'd0);
        step(1'b0, OP_LW, 1'b1, 4'd1);
        step(1'b0, OP_LW, 1'b1, 4'd2);
        step(1'b0, OP_LW, 1'b0, 4'd3);
        step(1'b0, OP_LW, 1'b0, 4'd3);
        step(1'b0, OP_LW, 1'b1, 4'd3);
        step(1'b0, OP_LW, 1'b1, 4'd4);
        step(1'b0, OP_SW, 1'b1, 4'd0);
        step(1'b0, OP_SW, 1'b1, 4'd1);
        step(1'b0, OP_SW, 1'b1, 4'd2);
        step(1'b0, OP_SW, 1'b0, 4'd5);
        step(1'b0, OP_SW, 1'b1, 4'd5);
`else
        // memReady low has no effect without wait states
        run(OP_LW, 5, 32'h43210, 1'b0);
        run(OP_SW, 4, 32'h5210,  1'b0);
`endif
        step(1'b0, OP_BEQ, 1'b1, 4'd0);
        @(negedge CLK);
        @(posedge CLK);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
